// File: rtl/branch_resolver.sv
// Per-thread branch resolution for the barrel-threaded control path.
// Produces jump/destination for the PC controller, one cycle after issue.
module branch_resolver #(
  parameter int PC_WIDTH          = 10,
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int COUNTER_WIDTH     = 10,
  parameter int INITIAL_THREAD    = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         branch_valid,
  input  logic [1:0]                   branch_type,
  input  logic [PC_WIDTH-1:0]          branch_target,
  input  logic                         operand_zero,
  input  logic                         IO_ready,
  input  logic                         counter_load_valid,
  input  logic [THREAD_ADDR_WIDTH-1:0] counter_load_thread,
  input  logic [COUNTER_WIDTH-1:0]     counter_load_value,
  output logic                         jump,
  output logic [PC_WIDTH-1:0]          branch_destination,
  output logic [THREAD_ADDR_WIDTH-1:0] jump_thread,
  output logic                         loop_exit
);

  localparam int TAW = THREAD_ADDR_WIDTH;
  localparam int CW  = COUNTER_WIDTH;

  localparam logic [TAW-1:0] LAST_THREAD =
    TAW'(THREAD_COUNT - 1);
  localparam logic [TAW-1:0] FIRST_THREAD =
    TAW'(INITIAL_THREAD);

  logic [TAW-1:0] cur_thread;
  logic [CW-1:0]  cnt [THREAD_COUNT];
  logic [CW-1:0]  cur_cnt;

  logic ok;
  logic is_jmp;
  logic is_jz;
  logic is_jnz;
  logic is_djnz;
  logic cnt_nz;
  logic taken;
  logic djnz_dec;
  logic djnz_exit;

  assign cur_cnt = cnt[cur_thread];
  assign ok      = branch_valid & IO_ready;
  assign cnt_nz  = |cur_cnt;

  assign is_jmp  = branch_type == 2'b00;
  assign is_jz   = branch_type == 2'b01;
  assign is_jnz  = branch_type == 2'b10;
  assign is_djnz = branch_type == 2'b11;

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      is_jmp:  taken = ok;
      is_jz:   taken = ok & operand_zero;
      is_jnz:  taken = ok & ~operand_zero;
      is_djnz: taken = ok & cnt_nz;
      default: taken = 1'b0;
    endcase
  end

  assign djnz_dec  = ok & is_djnz & cnt_nz;
  assign djnz_exit = ok & is_djnz & ~cnt_nz;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_thread         <= FIRST_THREAD;
      jump               <= 1'b0;
      loop_exit          <= 1'b0;
      branch_destination <= '0;
      jump_thread        <= '0;
    end else begin
      cur_thread <= (cur_thread == LAST_THREAD)
                    ? '0 : cur_thread + TAW'(1);
      jump        <= taken;
      loop_exit   <= djnz_exit;
      jump_thread <= cur_thread;
      if (taken)
        branch_destination <= branch_target;
    end
  end

  // A load to the issuing thread overrides that thread's decrement.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < THREAD_COUNT; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        if (counter_load_valid &&
            counter_load_thread == TAW'(i))
          cnt[i] <= counter_load_value;
        else if (djnz_dec && cur_thread == TAW'(i))
          cnt[i] <= cur_cnt - CW'(1);
      end
    end
  end

endmodule
